// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops bytes from the APB TX FIFO and sends start, 8 data (LSB first),
// optional 9th and stop bits. Define UART_TX_PARITY_EN to make the 9th bit even parity.
module uart_tx_engine #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned OSR_HI = 16,
   parameter int unsigned OSR_LO = 8
) (
   input  logic       pclk,
   input  logic       prst,
   input  logic       apb_tx_en,
   input  logic [7:0] apb_data,
   input  logic [7:0] apb_brg,
   input  logic       apb_bsel,
   input  logic       apb_d9,
   output logic       tx_txff_rd,
   output logic       tx_busy,
   output logic       uart_txd
);

   typedef enum logic [2:0] {StIdle, StStart, StData, StNinth, StStop} state_e;

   localparam logic [3:0] OsrHiLast = 4'(OSR_HI - 1);
   localparam logic [3:0] OsrLoLast = 4'(OSR_LO - 1);
   localparam logic [2:0] DataLast  = 3'(DATA_W - 1);

   state_e     state_q;
   logic [7:0] psc_q;
   logic [3:0] tick_q;
   logic [2:0] bit_idx_q;
   logic [7:0] shreg_q;
   logic       ninth_bit;
   logic       os_tick;
   logic       bit_end;

`ifdef UART_TX_PARITY_EN
   logic par_q;

   always_ff @(posedge pclk) begin
      if (prst) begin
         par_q <= 1'b0;
      end else if (state_q == StIdle && apb_tx_en) begin
         par_q <= ^apb_data;
      end
   end

   assign ninth_bit = par_q;
`else
   assign ninth_bit = 1'b1;
`endif

   // Baud rate inputs are used live; the APB side only changes them while disabled.
   always_comb begin
      os_tick = (psc_q == apb_brg);
      bit_end = os_tick && (tick_q == (apb_bsel ? OsrLoLast : OsrHiLast));
   end

   always_ff @(posedge pclk) begin
      if (prst) begin
         state_q    <= StIdle;
         psc_q      <= 8'd0;
         tick_q     <= 4'd0;
         bit_idx_q  <= 3'd0;
         shreg_q    <= 8'd0;
         tx_txff_rd <= 1'b0;
         tx_busy    <= 1'b0;
         uart_txd   <= 1'b1;
      end else begin
         tx_txff_rd <= 1'b0;

         // Every state change happens on bit_end, so clearing there also clears on transitions.
         if (state_q == StIdle || bit_end) begin
            psc_q  <= 8'd0;
            tick_q <= 4'd0;
         end else if (os_tick) begin
            psc_q  <= 8'd0;
            tick_q <= tick_q + 4'd1;
         end else begin
            psc_q <= psc_q + 8'd1;
         end

         case (state_q)
            StIdle: begin
               if (apb_tx_en) begin
                  state_q    <= StStart;
                  shreg_q    <= apb_data;
                  bit_idx_q  <= 3'd0;
                  tx_txff_rd <= 1'b1;
                  tx_busy    <= 1'b1;
                  uart_txd   <= 1'b0;
               end
            end
            StStart: begin
               if (bit_end) begin
                  state_q  <= StData;
                  uart_txd <= shreg_q[0];
                  shreg_q  <= {1'b0, shreg_q[7:1]};
               end
            end
            StData: begin
               if (bit_end) begin
                  bit_idx_q <= bit_idx_q + 3'd1;
                  shreg_q   <= {1'b0, shreg_q[7:1]};
                  if (bit_idx_q == DataLast) begin
                     if (apb_d9) begin
                        state_q  <= StNinth;
                        uart_txd <= ninth_bit;
                     end else begin
                        state_q  <= StStop;
                        uart_txd <= 1'b1;
                     end
                  end else begin
                     uart_txd <= shreg_q[0];
                  end
               end
            end
            StNinth: begin
               if (bit_end) begin
                  state_q  <= StStop;
                  uart_txd <= 1'b1;
               end
            end
            StStop: begin
               if (bit_end) begin
                  state_q  <= StIdle;
                  tx_busy  <= 1'b0;
                  uart_txd <= 1'b1;
               end
            end
            default: begin
               state_q  <= StIdle;
               tx_busy  <= 1'b0;
               uart_txd <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: expected line waveforms come from a frame model
// (bit list times bit period); honours UART_TX_PARITY_EN for the 9th-bit value.
module tb_uart_tx_engine;

`ifdef UART_TX_PARITY_EN
   localparam bit ParityBuild = 1'b1;
`else
   localparam bit ParityBuild = 1'b0;
`endif

   logic       pclk = 1'b0;
   logic       prst;
   logic       apb_tx_en;
   logic [7:0] apb_data;
   logic [7:0] apb_brg;
   logic       apb_bsel;
   logic       apb_d9;
   logic       tx_txff_rd;
   logic       tx_busy;
   logic       uart_txd;

   int n_assert = 0;
   int n_fail   = 0;
   int n_strobe = 0;
   int cyc      = 0;

   uart_tx_engine dut (
      .pclk       (pclk),
      .prst       (prst),
      .apb_tx_en  (apb_tx_en),
      .apb_data   (apb_data),
      .apb_brg    (apb_brg),
      .apb_bsel   (apb_bsel),
      .apb_d9     (apb_d9),
      .tx_txff_rd (tx_txff_rd),
      .tx_busy    (tx_busy),
      .uart_txd   (uart_txd)
   );

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;
   always @(negedge pclk) if (tx_txff_rd === 1'b1) n_strobe++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b, expected %b (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Even parity makes the total count of ones even; without it the 9th bit is an extra stop bit.
   function automatic logic ninth_of(input logic [7:0] d);
      logic odd;
      odd = ($countones(d) % 2) == 1;
      return ParityBuild ? odd : 1'b1;
   endfunction

   task automatic idle_check(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge pclk); #1;
         chk("idle_txd", uart_txd, 1'b1);
         chk("idle_busy", tx_busy, 1'b0);
         chk("idle_rd", tx_txff_rd, 1'b0);
      end
   endtask

   // Called #1 after an edge with the engine idle; the next edge is the load edge.
   task automatic send(input logic [7:0] d, input logic [7:0] d_next, input logic [7:0] brg,
                       input logic bsel, input logic d9, input logic hold, output int start_cyc);
      int          n;
      int          len;
      logic [10:0] bits;
      n    = (int'(brg) + 1) * (bsel ? 8 : 16);
      bits = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i + 1] = d[i];
      if (d9) begin
         bits[9]  = ninth_of(d);
         bits[10] = 1'b1;
         len      = 11;
      end else begin
         bits[9] = 1'b1;
         len     = 10;
      end
      apb_data  = d;
      apb_brg   = brg;
      apb_bsel  = bsel;
      apb_d9    = d9;
      apb_tx_en = 1'b1;
      @(posedge pclk); #1;
      start_cyc = cyc;
      apb_data  = d_next;
      if (!hold) apb_tx_en = 1'b0;
      for (int k = 0; k < len * n; k++) begin
         chk("frame_txd", uart_txd, bits[k / n]);
         chk("frame_busy", tx_busy, 1'b1);
         chk("frame_rd", tx_txff_rd, k == 0);
         @(posedge pclk); #1;
      end
      chk("end_txd", uart_txd, 1'b1);
      chk("end_busy", tx_busy, 1'b0);
      chk("end_rd", tx_txff_rd, 1'b0);
   endtask

   initial begin
      int          t0;
      int          t1;
      int          s0;
      logic [7:0]  ab;
      logic [7:0]  rd_data;
      logic [7:0]  rd_brg;
      logic        rd_bsel;
      logic        rd_d9;

      prst      = 1'b1;
      apb_tx_en = 1'b1;
      apb_data  = 8'h5A;
      apb_brg   = 8'd0;
      apb_bsel  = 1'b1;
      apb_d9    = 1'b0;

      // Reset held with a pending load: reset wins every cycle.
      for (int i = 0; i < 3; i++) begin
         @(posedge pclk); #1;
         chk("rst_txd", uart_txd, 1'b1);
         chk("rst_busy", tx_busy, 1'b0);
         chk("rst_rd", tx_txff_rd, 1'b0);
      end
      apb_tx_en = 1'b0;
      prst      = 1'b0;
      idle_check(10);

      s0 = n_strobe;
      send(8'h55, 8'h55, 8'd0, 1'b1, 1'b0, 1'b0, t0);
      chk_int("strobes_55", n_strobe - s0, 1);
      idle_check(2);

      send(8'hA3, 8'hA3, 8'd2, 1'b0, 1'b0, 1'b0, t0);
      idle_check(2);

      send(8'h07, 8'h07, 8'd0, 1'b1, 1'b1, 1'b0, t0);
      idle_check(2);
      send(8'h03, 8'h03, 8'd0, 1'b1, 1'b1, 1'b0, t0);
      idle_check(2);

      // Back-to-back: FIFO head advances after the first pop while tx_en stays high.
      s0 = n_strobe;
      send(8'h00, 8'hFF, 8'd0, 1'b1, 1'b0, 1'b1, t0);
      send(8'hFF, 8'hFF, 8'd0, 1'b1, 1'b0, 1'b0, t1);
      chk_int("b2b_gap", t1 - t0, 81);
      chk_int("b2b_strobes", n_strobe - s0, 2);
      idle_check(3);

      // Reset during data bit 3 aborts the frame without another pop.
      s0        = n_strobe;
      ab        = 8'hB6;
      apb_data  = ab;
      apb_brg   = 8'd0;
      apb_bsel  = 1'b1;
      apb_d9    = 1'b0;
      apb_tx_en = 1'b1;
      @(posedge pclk); #1;
      apb_tx_en = 1'b0;
      repeat (4 * 8 + 4) @(posedge pclk);
      #1;
      chk("abort_bit3", uart_txd, ab[3]);
      chk("abort_busy_before", tx_busy, 1'b1);
      prst = 1'b1;
      @(posedge pclk); #1;
      prst = 1'b0;
      chk("abort_txd", uart_txd, 1'b1);
      chk("abort_busy", tx_busy, 1'b0);
      chk("abort_rd", tx_txff_rd, 1'b0);
      idle_check(5);
      chk_int("abort_strobes", n_strobe - s0, 1);
      send(8'h3C, 8'h3C, 8'd0, 1'b1, 1'b0, 1'b0, t0);
      idle_check(1);

      // Randomised frames over rates and 9th-bit setting.
      for (int r = 0; r < 6; r++) begin
         rd_data = 8'($urandom);
         rd_brg  = 8'($urandom_range(0, 3));
         rd_bsel = 1'($urandom_range(0, 1));
         rd_d9   = 1'($urandom_range(0, 1));
         s0      = n_strobe;
         send(rd_data, rd_data, rd_brg, rd_bsel, rd_d9, 1'b0, t0);
         chk_int("rand_strobes", n_strobe - s0, 1);
         idle_check(int'($urandom_range(1, 4)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
